// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write bypass, load-use hazard detection,
// stall/flush control and the ID/EX pipeline register feeding execute.
module decode_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int REG_CNT  = 32,
   parameter int LINK_REG = 31,
   parameter int CTRL_W   = 16,
   parameter int CNT_W    = 16,
   localparam int AW      = $clog2(REG_CNT)
) (
   input  logic              Clk_in,
   input  logic              Reset,
   input  logic              if_valid,
   input  logic [31:0]       Instruction_in,
   input  logic [DATA_W-1:0] PCAddResult_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              dec_uses_rs,
   input  logic              dec_uses_rt,
   input  logic              dec_mem_read,
   input  logic              dec_reg_write,
   input  logic              dec_reg_dst,
   input  logic              dec_jal,
   input  logic              dec_zero_ext,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              id_stall,
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic              ex_reg_write,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [AW-1:0]     ex_dest,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [AW-1:0]    LINK_IDX = AW'(LINK_REG);
   localparam logic [AW-1:0]    ZERO_IDX = {AW{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [DATA_W-1:0] regFile [REG_CNT];

   logic [AW-1:0]     rsIdx;
   logic [AW-1:0]     rtIdx;
   logic [AW-1:0]     rdIdx;
   logic [AW-1:0]     destIdx;
   logic [15:0]       immField;
   logic [DATA_W-1:0] rsRead;
   logic [DATA_W-1:0] rtRead;
   logic [DATA_W-1:0] immExt;
   logic              loadUse;
   logic              unusedOpcode;

   assign rsIdx        = Instruction_in[21 +: AW];
   assign rtIdx        = Instruction_in[16 +: AW];
   assign rdIdx        = Instruction_in[11 +: AW];
   assign immField     = Instruction_in[15:0];
   assign unusedOpcode = ^Instruction_in[31:26];

   // Operand reads: register 0 is hardwired zero, a same-cycle writeback wins over the array.
   always_comb begin
      rsRead = ZERO_DATA;
      rtRead = ZERO_DATA;
      if (rsIdx == ZERO_IDX) begin
         rsRead = ZERO_DATA;
      end else if (wb_we && (wb_addr == rsIdx)) begin
         rsRead = wb_data;
      end else begin
         rsRead = regFile[rsIdx];
      end
      if (rtIdx == ZERO_IDX) begin
         rtRead = ZERO_DATA;
      end else if (wb_we && (wb_addr == rtIdx)) begin
         rtRead = wb_data;
      end else begin
         rtRead = regFile[rtIdx];
      end
   end

   // Immediate extension and destination selection (JAL links to LINK_REG).
   always_comb begin
      immExt  = ZERO_DATA;
      destIdx = ZERO_IDX;
      if (dec_zero_ext) begin
         immExt = {{(DATA_W-16){1'b0}}, immField};
      end else begin
         immExt = {{(DATA_W-16){immField[15]}}, immField};
      end
      if (dec_jal) begin
         destIdx = LINK_IDX;
      end else if (dec_reg_dst) begin
         destIdx = rdIdx;
      end else begin
         destIdx = rtIdx;
      end
   end

   assign loadUse = if_valid && ex_valid && ex_mem_read && (ex_dest != ZERO_IDX) &&
                    ((dec_uses_rs && (rsIdx == ex_dest)) || (dec_uses_rt && (rtIdx == ex_dest)));

   // A redirect kills the ID instruction, so there is nothing left to hold.
   assign id_stall = !flush && (loadUse || ex_stall);

   // Register file write port; register 0 is never written.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         for (int i = 0; i < REG_CNT; i++) begin
            regFile[i] <= ZERO_DATA;
         end
      end else if (wb_we && (wb_addr != ZERO_IDX)) begin
         regFile[wb_addr] <= wb_data;
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         stall_count <= {CNT_W{1'b0}};
      end else if (loadUse && !flush && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // ID/EX register: data fields always load when EX accepts; only valid reflects bubbles.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         ex_valid     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_ctrl      <= {CTRL_W{1'b0}};
         ex_pc        <= ZERO_DATA;
         ex_rs_data   <= ZERO_DATA;
         ex_rt_data   <= ZERO_DATA;
         ex_imm       <= ZERO_DATA;
         ex_rs        <= ZERO_IDX;
         ex_rt        <= ZERO_IDX;
         ex_dest      <= ZERO_IDX;
      end else if (!ex_stall) begin
         ex_valid     <= if_valid && !flush && !loadUse;
         ex_mem_read  <= dec_mem_read;
         ex_reg_write <= dec_reg_write || dec_jal;
         ex_ctrl      <= ctrl_in;
         ex_pc        <= PCAddResult_in;
         ex_rs_data   <= dec_jal ? PCAddResult_in : rsRead;
         ex_rt_data   <= rtRead;
         ex_imm       <= immExt;
         ex_rs        <= rsIdx;
         ex_rt        <= rtIdx;
         ex_dest      <= destIdx;
      end
   end

endmodule
